// File: rtl/tiny_cpu_pkg.sv
// Shared encodings for the tiny accumulator-style CPU core: opcodes, ALU
// functions and the FETCH/EXEC control states.
package tiny_cpu_pkg;

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_ST  = 2'b01;
  localparam logic [1:0] OP_ALU = 2'b10;
  localparam logic [1:0] OP_JZ  = 2'b11;

  localparam logic [1:0] F_ADD = 2'b00;
  localparam logic [1:0] F_SUB = 2'b01;
  localparam logic [1:0] F_AND = 2'b10;
  localparam logic [1:0] F_XOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/tiny_cpu_alu.sv
// Combinational ALU for the core: ADD/SUB/AND/XOR, modulo 2^DW, no flags.
module tiny_cpu_alu
  import tiny_cpu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [1:0]    func,
  output logic [DW-1:0] y
);

  always_comb begin
    y = '0;
    case (func)
      F_ADD:   y = a + b;
      F_SUB:   y = a - b;
      F_AND:   y = a & b;
      F_XOR:   y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/tiny_cpu_core.sv
// Two-cycle-per-instruction accumulator CPU with host load port, run/halt
// control and memory-mapped I/O words at the top two addresses.
module tiny_cpu_core
  import tiny_cpu_pkg::*;
#(
  parameter int DW          = 8,
  parameter int MEM_DEPTH   = 32,
  parameter int DATA_BASE   = 16,
  parameter int IO_IN_ADDR  = MEM_DEPTH - 2,
  parameter int IO_OUT_ADDR = MEM_DEPTH - 1,
  localparam int AW         = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  input  logic [DW-1:0] io_in,
  output logic [DW-1:0] io_out,
  output logic          busy,
  output logic          halted,
  output logic [AW-1:0] pc_out,
  output state_t        dbg_state
);

  localparam logic [AW-1:0] IO_IN_IDX  = AW'(IO_IN_ADDR);
  localparam logic [AW-1:0] IO_OUT_IDX = AW'(IO_OUT_ADDR);
  localparam logic [AW-1:0] BASE_IDX   = AW'(DATA_BASE);

  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [7:0]    r_ir;
  logic [DW-1:0] r_regs [4];
  logic [DW-1:0] r_mem  [MEM_DEPTH];
  logic [DW-1:0] r_io_out;

  state_t        w_state_nxt;
  logic [AW-1:0] w_pc_nxt;
  logic          w_ir_load;
  logic          w_reg_we;
  logic [DW-1:0] w_reg_wdata;
  logic          w_st_we;
  logic          w_host_we;

  logic [1:0]    w_op;
  logic [1:0]    w_ra;
  logic [1:0]    w_rb;
  logic [1:0]    w_func;
  logic [3:0]    w_imm4;
  logic [AW-1:0] w_data_addr;
  logic [AW-1:0] w_jz_target;
  logic [DW-1:0] w_ra_val;
  logic [DW-1:0] w_rb_val;
  logic [DW-1:0] w_alu_y;

  assign w_op        = r_ir[7:6];
  assign w_ra        = r_ir[5:4];
  assign w_rb        = r_ir[3:2];
  assign w_func      = r_ir[1:0];
  assign w_imm4      = r_ir[3:0];
  assign w_data_addr = BASE_IDX + {{(AW-4){1'b0}}, w_imm4};
  assign w_jz_target = {{(AW-4){1'b0}}, w_imm4};
  assign w_ra_val    = r_regs[w_ra];
  assign w_rb_val    = r_regs[w_rb];

  tiny_cpu_alu #(
    .DW (DW)
  ) u_alu (
    .a    (w_ra_val),
    .b    (w_rb_val),
    .func (w_func),
    .y    (w_alu_y)
  );

  // run and load_we are single-cycle strobes sampled at the clock edge. Both
  // are accepted only in IDLE/HALT (busy=0); there is no ready back to the host.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_load   = 1'b0;
    w_reg_we    = 1'b0;
    w_reg_wdata = '0;
    w_st_we     = 1'b0;
    w_host_we   = 1'b0;
    unique case (r_state)
      IDLE, HALT: begin
        w_host_we = load_we;
        if (run) begin
          w_state_nxt = FETCH;
          w_pc_nxt    = '0;
        end
      end
      FETCH: begin
        w_ir_load   = 1'b1;
        w_state_nxt = EXEC;
      end
      EXEC: begin
        w_state_nxt = FETCH;
        w_pc_nxt    = r_pc + AW'(1);
        case (w_op)
          OP_LD: begin
            w_reg_we    = 1'b1;
            w_reg_wdata = r_mem[w_data_addr];
          end
          OP_ST: w_st_we = 1'b1;
          OP_ALU: begin
            w_reg_we    = 1'b1;
            w_reg_wdata = w_alu_y;
          end
          default: begin
            // A taken jump onto itself is the program's halt idiom.
            if (w_ra_val == '0) begin
              if (w_jz_target == r_pc) begin
                w_state_nxt = HALT;
                w_pc_nxt    = r_pc;
              end else begin
                w_pc_nxt = w_jz_target;
              end
            end
          end
        endcase
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_ir_load) r_ir <= r_mem[r_pc][7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else if (w_reg_we) begin
      r_regs[w_ra] <= w_reg_wdata;
    end
  end

  // The io_in write comes last so it overrides any store to the same word.
  always_ff @(posedge clk) begin
    if (w_host_we) r_mem[load_addr] <= load_data;
    if (w_st_we) r_mem[w_data_addr] <= w_ra_val;
    r_mem[IO_IN_IDX] <= io_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_io_out <= '0;
    else        r_io_out <= r_mem[IO_OUT_IDX];
  end

  assign io_out    = r_io_out;
  assign busy      = (r_state == FETCH) || (r_state == EXEC);
  assign halted    = (r_state == HALT);
  assign pc_out    = r_pc;
  assign dbg_state = r_state;

endmodule
